instr_regfile_alu_pipe: RTL and testbench
=========================================

Name: instr_regfile_alu_pipe

Overview:
Parametrised next-generation instruction register file with integrated signed ALU. Accepts {opcode, operand_a, operand_b, write_pointer} over a valid/ready handshake. Computes the result in a registered pipeline, using an iterative multi-cycle divider for DIV/MOD. Stores {opcode, a, b, result, flags} per entry and serves a registered read port. Sits between the instruction stimulus/driver side and the downstream consumer/checker.

Parameters:
OP_WIDTH, 32, operand width in bits; operands are signed two's complement; minimum 4.
DEPTH, 32, number of entries; power of two, 2..256.
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.
RES_WIDTH, 2*OP_WIDTH, result width in bits.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request this cycle.
opcode  in  3  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD.
operand_a  in  OP_WIDTH  signed operand A.
operand_b  in  OP_WIDTH  signed operand B.
write_pointer  in  ADDR_W  destination entry.
rd_en  in  1  read request.
read_pointer  in  ADDR_W  entry to read.
rd_valid  out  1  read data valid (one-cycle pulse).
rd_opcode  out  3  stored opcode.
rd_operand_a  out  OP_WIDTH  stored A.
rd_operand_b  out  OP_WIDTH  stored B.
rd_result  out  RES_WIDTH  stored signed result.
rd_written  out  1  entry has been written since reset.
rd_div_zero  out  1  entry was a DIV/MOD with operand_b == 0.
busy  out  1  a request is in the pipeline or in the divider.

Behaviour:
- Reset (async assert): clear every entry to opcode ZERO, operands 0, result 0, written 0, div_zero 0. Outputs: in_ready=1, rd_valid=0, all rd_* = 0, busy=0. Reset mid-divide aborts the operation; nothing is written.
- Accept: a request is accepted on an edge where in_valid && in_ready. Inputs are captured into the stage register. When in_ready is low, inputs are ignored and no stall buffer exists.
- Non-divide opcodes (0–5), and DIV/MOD with b==0: the result is written to iw[write_pointer] on the edge after the accepting edge (latency 1). Throughput is one per cycle and in_ready stays 1.
- DIV/MOD with b!=0: FSM states IDLE -> DIV_RUN -> DIV_DONE -> IDLE.
  - Accept at edge N moves the FSM to DIV_RUN, and in_ready drops after edge N.
  - The restoring divider runs on magnitudes for OP_WIDTH cycles.
  - DIV_DONE writes the entry at edge N+OP_WIDTH+1. in_ready returns to 1 after that edge (IDLE).
  - busy is 1 from after edge N through that write edge.
- Arithmetic: all results are sign-extended to RES_WIDTH.
  - ZERO gives 0. PASSA gives a. PASSB gives b.
  - ADD gives a+b and SUB gives a-b, computed at OP_WIDTH+1 bits and sign-extended, with no wrap.
  - MULT gives the full signed product.
  - DIV truncates toward zero. MOD remainder takes the sign of the dividend.
  - DIV/MOD with b==0 gives result 0, div_zero=1.
  - DIV of the most-negative value by -1 gives +2^(OP_WIDTH-1), representable in RES_WIDTH.
- Written flag: set to 1 on every write. div_zero is rewritten on every write (0 for non-DIV/MOD).
- Read: rd_en sampled at edge M puts entry contents on rd_* after edge M (latency 1), with rd_valid=1 for that cycle. rd_* hold their value when rd_en=0, while rd_valid=0.
- Read and write to the same entry on the same edge: the read returns the pre-write contents.
- Pointer wrap: pointers are ADDR_W wide, so every value is a legal entry.
- busy is 1 whenever the stage register holds an unwritten request or the FSM is not IDLE.

Test Plan:
- Reset then read all DEPTH entries -> every read gives rd_valid=1, opcode 0, operands 0, result 0, rd_written=0.
- Back-to-back ADD a=5,b=-3 to ptr 1, then SUB a=-128,b=1 to ptr 2, then MULT a=-7,b=6 to ptr 3; in_ready held 1 -> reads give results 2, -129, -42 (sign-extended), each written 1 cycle after accept.
- DIV a=-17,b=5 to ptr 4 -> in_ready low for OP_WIDTH+1 cycles, then entry result -3. MOD a=-17,b=5 -> result -2. New request held during the stall is accepted only when in_ready returns to 1.
- DIV a=9,b=0 to ptr 5 -> written after 1 cycle with result 0 and rd_div_zero=1. Next write of PASSA to ptr 5 -> rd_div_zero=0.
- Write PASSB b=77 to ptr 6 with read of ptr 6 on the commit edge -> old contents returned; a read one cycle later returns 77.
- Assert reset_n low 10 cycles into a DIV to ptr 7 -> no write (rd_written=0), in_ready=1 and busy=0 immediately after reset.

Source files
------------

// File: rtl/instr_regfile_alu_pipe.sv
// Instruction register file with an integrated signed ALU.
// Single-cycle ops commit one edge after accept; DIV/MOD use an iterative restoring divider.
module instr_regfile_alu_pipe #(
    parameter  int unsigned OP_WIDTH  = 32,
    parameter  int unsigned DEPTH     = 32,
    localparam int unsigned ADDR_W    = $clog2(DEPTH),
    localparam int unsigned RES_WIDTH = 2 * OP_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           opcode,
    input  logic [OP_WIDTH-1:0]  operand_a,
    input  logic [OP_WIDTH-1:0]  operand_b,
    input  logic [ADDR_W-1:0]    write_pointer,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    read_pointer,
    output logic                 rd_valid,
    output logic [2:0]           rd_opcode,
    output logic [OP_WIDTH-1:0]  rd_operand_a,
    output logic [OP_WIDTH-1:0]  rd_operand_b,
    output logic [RES_WIDTH-1:0] rd_result,
    output logic                 rd_written,
    output logic                 rd_div_zero,
    output logic                 busy
);

    localparam int unsigned CNT_W = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
    localparam int unsigned EXT_W = RES_WIDTH - OP_WIDTH;

    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;

    typedef struct packed {
        logic [2:0]           op;
        logic [OP_WIDTH-1:0]  a;
        logic [OP_WIDTH-1:0]  b;
        logic [RES_WIDTH-1:0] res;
        logic                 written;
        logic                 div_zero;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_RUN  = 2'd1,
        S_DIV_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         w_div_step;
    logic                         w_div_commit;

    logic                         r_in_ready;
    logic                         r_busy;

    logic                         r_stg_valid;
    logic [2:0]                   r_stg_op;
    logic signed [OP_WIDTH-1:0]   r_stg_a;
    logic signed [OP_WIDTH-1:0]   r_stg_b;
    logic [ADDR_W-1:0]            r_stg_ptr;

    logic [OP_WIDTH-1:0]          r_rem;
    logic [OP_WIDTH-1:0]          r_quo;
    logic [OP_WIDTH-1:0]          r_dvs;
    logic [CNT_W-1:0]             r_cnt;

    entry_t                       r_mem [DEPTH];
    entry_t                       r_rd_entry;
    logic                         r_rd_valid;

    logic                         w_accept;
    logic                         w_div_start;
    logic                         w_stg_valid_nxt;
    logic [OP_WIDTH-1:0]          w_mag_a;
    logic [OP_WIDTH-1:0]          w_mag_b;

    logic signed [OP_WIDTH:0]     w_sum;
    logic signed [OP_WIDTH:0]     w_diff;
    logic signed [RES_WIDTH-1:0]  w_ax;
    logic signed [RES_WIDTH-1:0]  w_bx;
    logic signed [RES_WIDTH-1:0]  w_prod;
    logic [RES_WIDTH-1:0]         w_alu_res;

    logic [OP_WIDTH:0]            w_rem_sh;
    logic [OP_WIDTH:0]            w_rem_sub;
    logic                         w_rem_ge;
    logic [RES_WIDTH-1:0]         w_quo_ext;
    logic [RES_WIDTH-1:0]         w_rem_ext;
    logic [RES_WIDTH-1:0]         w_div_res;

    logic                         w_wr_en;
    logic [ADDR_W-1:0]            w_wr_ptr;
    entry_t                       w_wr_entry;

    // Request decode; DIV/MOD by zero takes the single-cycle path
    assign w_accept        = in_valid && r_in_ready;
    assign w_div_start     = w_accept && (opcode[2:1] == 2'b11) && (operand_b != '0);
    assign w_stg_valid_nxt = w_accept && !w_div_start;
    assign w_mag_a         = operand_a[OP_WIDTH-1] ? OP_WIDTH'(OP_WIDTH'(0) - operand_a) : operand_a;
    assign w_mag_b         = operand_b[OP_WIDTH-1] ? OP_WIDTH'(OP_WIDTH'(0) - operand_b) : operand_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_div_step   = 1'b0;
        w_div_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_div_start) begin
                    w_state_nxt = S_DIV_RUN;
                end
            end
            S_DIV_RUN: begin
                w_div_step = 1'b1;
                if (r_cnt == CNT_W'(OP_WIDTH - 1)) begin
                    w_state_nxt = S_DIV_DONE;
                end
            end
            S_DIV_DONE: begin
                w_div_commit = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stage register, divider datapath and handshake/status flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_stg_valid <= 1'b0;
            r_stg_op    <= '0;
            r_stg_a     <= '0;
            r_stg_b     <= '0;
            r_stg_ptr   <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_busy      <= w_stg_valid_nxt || (w_state_nxt != S_IDLE);
            r_stg_valid <= w_stg_valid_nxt;
            if (w_accept) begin
                r_stg_op  <= opcode;
                r_stg_a   <= operand_a;
                r_stg_b   <= operand_b;
                r_stg_ptr <= write_pointer;
            end
            if (w_div_start) begin
                r_rem <= '0;
                r_quo <= w_mag_a;
                r_dvs <= w_mag_b;
                r_cnt <= '0;
            end else if (w_div_step) begin
                r_rem <= w_rem_ge ? w_rem_sub[OP_WIDTH-1:0] : w_rem_sh[OP_WIDTH-1:0];
                r_quo <= {r_quo[OP_WIDTH-2:0], w_rem_ge};
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Restoring divider step on magnitudes
    assign w_rem_sh  = {r_rem, r_quo[OP_WIDTH-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_dvs};
    assign w_rem_ge  = !w_rem_sub[OP_WIDTH];

    // Quotient truncates toward zero; remainder follows the dividend sign
    assign w_quo_ext = {{EXT_W{1'b0}}, r_quo};
    assign w_rem_ext = {{EXT_W{1'b0}}, r_rem};
    always_comb begin
        w_div_res = '0;
        if (r_stg_op[0]) begin
            w_div_res = r_stg_a[OP_WIDTH-1] ? RES_WIDTH'(RES_WIDTH'(0) - w_rem_ext) : w_rem_ext;
        end else begin
            w_div_res = (r_stg_a[OP_WIDTH-1] ^ r_stg_b[OP_WIDTH-1])
                      ? RES_WIDTH'(RES_WIDTH'(0) - w_quo_ext) : w_quo_ext;
        end
    end

    assign w_sum  = $signed({r_stg_a[OP_WIDTH-1], r_stg_a}) + $signed({r_stg_b[OP_WIDTH-1], r_stg_b});
    assign w_diff = $signed({r_stg_a[OP_WIDTH-1], r_stg_a}) - $signed({r_stg_b[OP_WIDTH-1], r_stg_b});
    assign w_ax   = {{EXT_W{r_stg_a[OP_WIDTH-1]}}, r_stg_a};
    assign w_bx   = {{EXT_W{r_stg_b[OP_WIDTH-1]}}, r_stg_b};
    assign w_prod = w_ax * w_bx;

    always_comb begin
        w_alu_res = '0;
        case (r_stg_op)
            OP_PASSA: w_alu_res = w_ax;
            OP_PASSB: w_alu_res = w_bx;
            OP_ADD:   w_alu_res = {{(EXT_W - 1){w_sum[OP_WIDTH]}}, w_sum};
            OP_SUB:   w_alu_res = {{(EXT_W - 1){w_diff[OP_WIDTH]}}, w_diff};
            OP_MULT:  w_alu_res = w_prod;
            default:  w_alu_res = '0;
        endcase
    end

    // At most one commit source is active per cycle
    always_comb begin
        w_wr_en             = r_stg_valid || w_div_commit;
        w_wr_ptr            = r_stg_ptr;
        w_wr_entry          = '0;
        w_wr_entry.op       = r_stg_op;
        w_wr_entry.a        = r_stg_a;
        w_wr_entry.b        = r_stg_b;
        w_wr_entry.written  = 1'b1;
        w_wr_entry.res      = w_div_commit ? w_div_res : w_alu_res;
        w_wr_entry.div_zero = r_stg_valid && (r_stg_op[2:1] == 2'b11);
    end

    // Entry storage and registered read port (read sees pre-write contents)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[ADDR_W'(i)] <= '0;
            end
            r_rd_entry <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[w_wr_ptr] <= w_wr_entry;
            end
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_entry <= r_mem[read_pointer];
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign rd_valid     = r_rd_valid;
    assign rd_opcode    = r_rd_entry.op;
    assign rd_operand_a = r_rd_entry.a;
    assign rd_operand_b = r_rd_entry.b;
    assign rd_result    = r_rd_entry.res;
    assign rd_written   = r_rd_entry.written;
    assign rd_div_zero  = r_rd_entry.div_zero;

endmodule

// File: tb/tb_instr_regfile_alu_pipe.sv
// Directed bench for instr_regfile_alu_pipe at OP_WIDTH=8, DEPTH=8.
module tb_instr_regfile_alu_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned RW = 16;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    opcode;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [AW-1:0] write_pointer;
    logic          rd_en;
    logic [AW-1:0] read_pointer;
    logic          rd_valid;
    logic [2:0]    rd_opcode;
    logic [W-1:0]  rd_operand_a;
    logic [W-1:0]  rd_operand_b;
    logic [RW-1:0] rd_result;
    logic          rd_written;
    logic          rd_div_zero;
    logic          busy;

    int n_total;
    int n_bad;
    int n_cyc;

    instr_regfile_alu_pipe #(.OP_WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .write_pointer(write_pointer),
        .rd_en(rd_en), .read_pointer(read_pointer), .rd_valid(rd_valid),
        .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
        .rd_result(rd_result), .rd_written(rd_written), .rd_div_zero(rd_div_zero),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] p);
        in_valid      = 1'b1;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        write_pointer = p;
        tick();
        in_valid      = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] p);
        rd_en        = 1'b1;
        read_pointer = p;
        tick();
        rd_en        = 1'b0;
    endtask

    task automatic wait_ready();
        n_cyc = 0;
        while (in_ready !== 1'b1 && n_cyc < 100) begin
            n_cyc++;
            tick();
        end
        chk("ready_timeout", 64'(in_ready), 64'(1));
    endtask

    function automatic logic [63:0] obs_entry();
        return 64'({rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_written, rd_div_zero});
    endfunction

    function automatic logic [63:0] exp_entry(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [RW-1:0] r,
                                              input logic wr, input logic dz);
        return 64'({1'b1, op, a, b, r, wr, dz});
    endfunction

    initial begin
        n_total = 0; n_bad = 0;
        reset_n = 1'b0; in_valid = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
        write_pointer = '0; rd_en = 1'b0; read_pointer = '0;
        repeat (3) tick();
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_rd_out", obs_entry(), 64'(0));
        reset_n = 1'b1;
        tick();

        // Every entry cleared after reset
        for (int i = 0; i < int'(D); i++) begin
            rd(AW'(i));
            chk($sformatf("reset_entry%0d", i), obs_entry(), exp_entry(3'd0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0));
        end
        tick();
        chk("rd_valid_pulse", 64'(rd_valid), 64'(0));

        // Back-to-back single-cycle ops
        req(3'd3, 8'h05, 8'hFD, 3'd1);
        chk("add_ready", 64'(in_ready), 64'(1));
        chk("add_busy", 64'(busy), 64'(1));
        req(3'd4, 8'h80, 8'h01, 3'd2);
        chk("sub_ready", 64'(in_ready), 64'(1));
        req(3'd5, 8'hF9, 8'h06, 3'd3);
        chk("mult_busy", 64'(busy), 64'(1));
        rd(3'd3);
        chk("mult_pre_commit", obs_entry(), exp_entry(3'd0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0));
        chk("idle_busy", 64'(busy), 64'(0));
        rd(3'd3);
        chk("mult_result", obs_entry(), exp_entry(3'd5, 8'hF9, 8'h06, 16'hFFD6, 1'b1, 1'b0));
        rd(3'd1);
        chk("add_result", obs_entry(), exp_entry(3'd3, 8'h05, 8'hFD, 16'h0002, 1'b1, 1'b0));
        rd(3'd2);
        chk("sub_result", obs_entry(), exp_entry(3'd4, 8'h80, 8'h01, 16'hFF7F, 1'b1, 1'b0));

        // DIV stall, with a MOD request held until in_ready returns
        req(3'd6, 8'hEF, 8'h05, 3'd4);
        in_valid = 1'b1; opcode = 3'd7; write_pointer = 3'd0;
        chk("div_ready_low", 64'(in_ready), 64'(0));
        chk("div_busy", 64'(busy), 64'(1));
        n_cyc = 0;
        while (in_ready !== 1'b1 && n_cyc < 50) begin
            n_cyc++;
            tick();
        end
        chk("div_stall_cycles", 64'(n_cyc), 64'(W + 1));
        chk("div_done_busy", 64'(busy), 64'(0));
        tick();
        in_valid = 1'b0;
        chk("mod_accepted", 64'(in_ready), 64'(0));
        wait_ready();
        rd(3'd4);
        chk("div_result", obs_entry(), exp_entry(3'd6, 8'hEF, 8'h05, 16'hFFFD, 1'b1, 1'b0));
        rd(3'd0);
        chk("mod_result", obs_entry(), exp_entry(3'd7, 8'hEF, 8'h05, 16'hFFFE, 1'b1, 1'b0));

        // Most-negative / -1 and full-width product
        req(3'd6, 8'h80, 8'hFF, 3'd6);
        wait_ready();
        rd(3'd6);
        chk("div_min_neg1", obs_entry(), exp_entry(3'd6, 8'h80, 8'hFF, 16'h0080, 1'b1, 1'b0));
        req(3'd5, 8'h80, 8'h80, 3'd0);
        tick();
        rd(3'd0);
        chk("mult_min_min", obs_entry(), exp_entry(3'd5, 8'h80, 8'h80, 16'h4000, 1'b1, 1'b0));

        // Divide by zero commits in one cycle, flag cleared by next write
        req(3'd6, 8'h09, 8'h00, 3'd5);
        chk("divz_no_stall", 64'(in_ready), 64'(1));
        tick();
        rd(3'd5);
        chk("divz_entry", obs_entry(), exp_entry(3'd6, 8'h09, 8'h00, 16'h0000, 1'b1, 1'b1));
        req(3'd1, 8'h0C, 8'h00, 3'd5);
        tick();
        rd(3'd5);
        chk("passa_clears_dz", obs_entry(), exp_entry(3'd1, 8'h0C, 8'h00, 16'h000C, 1'b1, 1'b0));

        // Read and write the same entry on the commit edge
        req(3'd2, 8'h00, 8'h4D, 3'd6);
        rd(3'd6);
        chk("collide_old", obs_entry(), exp_entry(3'd6, 8'h80, 8'hFF, 16'h0080, 1'b1, 1'b0));
        rd(3'd6);
        chk("collide_new", obs_entry(), exp_entry(3'd2, 8'h00, 8'h4D, 16'h004D, 1'b1, 1'b0));
        tick();
        chk("hold_valid", 64'(rd_valid), 64'(0));
        chk("hold_result", 64'(rd_result), 64'(16'h004D));

        // Reset in the middle of a divide
        req(3'd6, 8'h64, 8'h07, 3'd7);
        repeat (4) tick();
        chk("middiv_busy", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        rd(3'd7);
        chk("rst_no_write", obs_entry(), exp_entry(3'd0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0));
        rd(3'd4);
        chk("rst_cleared", obs_entry(), exp_entry(3'd0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
